// File: rtl/alu_seq_ctrl.sv
// Multi-cycle add/subtract sequencer: accepts one request, runs one or two
// steps on a 2-bit-extended accumulator, and returns the exact signed result.
module alu_seq_ctrl #(
  parameter int N = 4
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [1:0]     op,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  input  logic [N-1:0]   c,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [N+1:0]   result,
  output logic           busy,
  output logic [7:0]     op_count,
  output logic [1:0]     state_dbg
);

  localparam int W = N + 2;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] STEP1 = 2'd1;
  localparam logic [1:0] STEP2 = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; valid never depends on ready, and ready/valid come from state.

  logic [1:0]   state_q, state_d;
  logic [1:0]   op_q, op_d;
  logic [N-1:0] a_q, a_d;
  logic [N-1:0] b_q, b_d;
  logic [N-1:0] c_q, c_d;
  logic [W-1:0] acc_q, acc_d;
  logic [7:0]   op_count_q, op_count_d;

  function automatic logic [W-1:0] ext(input logic [N-1:0] x);
    ext = {{2{x[N-1]}}, x};
  endfunction

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    a_d        = a_q;
    b_d        = b_q;
    c_d        = c_q;
    acc_d      = acc_q;
    op_count_d = op_count_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          op_d    = op;
          a_d     = a;
          b_d     = b;
          c_d     = c;
          state_d = STEP1;
        end
      end
      STEP1: begin
        // op[0] selects subtract for the first step
        if (op_q[0]) acc_d = ext(a_q) - ext(b_q);
        else         acc_d = ext(a_q) + ext(b_q);
        state_d = op_q[1] ? STEP2 : DONE;
      end
      STEP2: begin
        if (op_q[0]) acc_d = acc_q - ext(c_q);
        else         acc_d = acc_q + ext(c_q);
        state_d = DONE;
      end
      DONE: begin
        if (out_ready) begin
          state_d    = IDLE;
          op_count_d = op_count_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      c_q        <= '0;
      acc_q      <= '0;
      op_count_q <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      a_q        <= a_d;
      b_q        <= b_d;
      c_q        <= c_d;
      acc_q      <= acc_d;
      op_count_q <= op_count_d;
    end
  end

  assign in_ready  = reset_n & (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign result    = acc_q;
  assign op_count  = op_count_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed bench for alu_seq_ctrl: expected results are queued at accept and
// checked by an independent monitor at each result transfer.
module tb_alu_seq_ctrl;

  localparam int N = 4;
  localparam int W = N + 2;

  logic           clk;
  logic           reset_n;
  logic           in_valid;
  logic           in_ready;
  logic [1:0]     op;
  logic [N-1:0]   a, b, c;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   result;
  logic           busy;
  logic [7:0]     op_count;
  logic [1:0]     state_dbg;

  logic [W-1:0] exp_q[$];
  int vectors;
  int miscompares;

  alu_seq_ctrl #(.N(N)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .c         (c),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .busy      (busy),
    .op_count  (op_count),
    .state_dbg (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // scoreboard monitor: a transfer occurs at the next rising edge
  always @(negedge clk) begin
    if (reset_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_result: got %0d, expected none", result);
      end else begin
        check("result", {26'd0, result}, {26'd0, exp_q.pop_front()});
      end
    end
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] o, input int av, input int bv,
                       input int cv, input int expv);
    int n;
    logic [31:0] ev;
    n = 0;
    while (!in_ready && n < 50) begin
      step();
      n++;
    end
    if (!in_ready) check("accept_timeout", 32'd0, 32'd1);
    ev       = expv;
    op       = o;
    a        = av[N-1:0];
    b        = bv[N-1:0];
    c        = cv[N-1:0];
    in_valid = 1'b1;
    exp_q.push_back(ev[W-1:0]);
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!(exp_q.size() == 0 && in_ready) && n < 50) begin
      step();
      n++;
    end
    if (n >= 50) check("done_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    logic [31:0] e;
    vectors     = 0;
    miscompares = 0;
    reset_n     = 1'b0;
    in_valid    = 1'b0;
    out_ready   = 1'b1;
    op          = '0;
    a           = '0;
    b           = '0;
    c           = '0;

    #2;
    check("rst_in_ready", {31'd0, in_ready}, 0);
    check("rst_out_valid", {31'd0, out_valid}, 0);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_result", {26'd0, result}, 0);
    check("rst_op_count", {24'd0, op_count}, 0);
    step();
    step();
    reset_n = 1'b1;
    #1;
    check("rel_in_ready", {31'd0, in_ready}, 1);

    // 7 + 7, one-step latency
    issue(2'b00, 7, 7, 0, 14);
    check("add_lat_e0_valid", {31'd0, out_valid}, 0);
    check("add_lat_e0_busy", {31'd0, busy}, 1);
    step();
    check("add_lat_e1_valid", {31'd0, out_valid}, 1);
    step();
    check("add_post_valid", {31'd0, out_valid}, 0);
    check("add_post_in_ready", {31'd0, in_ready}, 1);
    check("add_op_count", {24'd0, op_count}, 1);

    // -8 + -8 + -8, two-step latency
    issue(2'b10, -8, -8, -8, -24);
    check("add3_e0_valid", {31'd0, out_valid}, 0);
    step();
    check("add3_e1_valid", {31'd0, out_valid}, 0);
    check("add3_e1_busy", {31'd0, busy}, 1);
    step();
    check("add3_e2_valid", {31'd0, out_valid}, 1);
    wait_done();

    issue(2'b01, -8, 7, 0, -15);
    wait_done();

    // positive extreme; operands scrambled after accept
    issue(2'b11, 7, -8, -8, 23);
    a = 4'd1;
    b = 4'd2;
    c = 4'd3;
    wait_done();
    check("sub3_op_count", {24'd0, op_count}, 4);

    // backpressure with a pending request
    out_ready = 1'b0;
    issue(2'b00, 3, -5, 0, -2);
    op       = 2'b00;
    a        = 4'd1;
    b        = 4'd2;
    in_valid = 1'b1;
    step();
    for (int i = 0; i < 5; i++) begin
      e = -2;
      check("bp_out_valid", {31'd0, out_valid}, 1);
      check("bp_in_ready", {31'd0, in_ready}, 0);
      check("bp_busy", {31'd0, busy}, 1);
      check("bp_result", {26'd0, result}, {26'd0, e[W-1:0]});
      check("bp_op_count", {24'd0, op_count}, 4);
      step();
    end
    out_ready = 1'b1;
    exp_q.push_back(6'd3);
    step();
    check("bp_xfer_valid", {31'd0, out_valid}, 0);
    check("bp_xfer_in_ready", {31'd0, in_ready}, 1);
    check("bp_xfer_count", {24'd0, op_count}, 5);
    step();
    in_valid = 1'b0;
    check("bp_next_busy", {31'd0, busy}, 1);
    wait_done();
    check("bp_final_count", {24'd0, op_count}, 6);

    // asynchronous reset during STEP2
    issue(2'b10, 1, 2, 3, 6);
    step();
    #2;
    reset_n = 1'b0;
    exp_q.delete();
    #1;
    check("mid_rst_out_valid", {31'd0, out_valid}, 0);
    check("mid_rst_busy", {31'd0, busy}, 0);
    check("mid_rst_result", {26'd0, result}, 0);
    check("mid_rst_in_ready", {31'd0, in_ready}, 0);
    check("mid_rst_op_count", {24'd0, op_count}, 0);
    step();
    reset_n = 1'b1;
    #1;
    issue(2'b00, 1, 1, 0, 2);
    wait_done();
    check("post_rst_count", {24'd0, op_count}, 1);

    // back-to-back adds up to the counter wrap
    for (int i = 0; i < 255; i++) begin
      int av, bv;
      av = (i % 16) - 8;
      bv = ((i * 3) % 16) - 8;
      issue(2'b00, av, bv, 0, av + bv);
      if (i == 253) begin
        wait_done();
        check("wrap_255", {24'd0, op_count}, 255);
      end
    end
    wait_done();
    check("wrap_0", {24'd0, op_count}, 0);
    check("queue_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
